// File: rtl/aes_pkg.sv
// Shared AES constants, types and GF(2^8) helpers used by the key schedule.
// The S-box is computed from the GF(2^8) inverse plus the affine map, so no table is stored.
package aes_pkg;

    localparam int NR = 10;

    typedef logic [31:0]  aes_word_t;
    typedef logic [127:0] aes_block_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } aes_ks_state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] aa;
        acc = 8'h00;
        aa  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ aa;
            aa = xtime(aa);
        end
        return acc;
    endfunction

    // Inverse as b^254 (zero maps to zero), then the FIPS-197 affine transform.
    function automatic logic [7:0] aes_sbox(input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] inv;
        p   = b;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p   = gf_mul(p, p);
            inv = gf_mul(inv, p);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

endpackage

// File: rtl/aes_key_step.sv
// One AES-128 key expansion step: next round key from the current one plus its rcon,
// and the rcon to use for the following step.
module aes_key_step
    import aes_pkg::*;
(
    input  aes_block_t i_key,
    input  logic [7:0] i_rcon,
    output aes_block_t o_key,
    output logic [7:0] o_rcon
);

    aes_word_t w_w0;
    aes_word_t w_w1;
    aes_word_t w_w2;
    aes_word_t w_w3;
    aes_word_t w_rot;
    aes_word_t w_sub;
    aes_word_t w_temp;
    aes_word_t w_n0;
    aes_word_t w_n1;
    aes_word_t w_n2;
    aes_word_t w_n3;

    assign w_w0  = i_key[127:96];
    assign w_w1  = i_key[95:64];
    assign w_w2  = i_key[63:32];
    assign w_w3  = i_key[31:0];
    assign w_rot = {w_w3[23:0], w_w3[31:24]};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sub
            assign w_sub[8*gi +: 8] = aes_sbox(w_rot[8*gi +: 8]);
        end
    endgenerate

    assign w_temp = w_sub ^ {i_rcon, 24'h000000};
    assign w_n0   = w_w0 ^ w_temp;
    assign w_n1   = w_w1 ^ w_n0;
    assign w_n2   = w_w2 ^ w_n1;
    assign w_n3   = w_w3 ^ w_n2;

    assign o_key  = {w_n0, w_n1, w_n2, w_n3};
    assign o_rcon = xtime(i_rcon);

endmodule

// File: rtl/aes_key_sched_seq.sv
// Sequential AES-128 key schedule: emits NR/CC round keys per cycle over CC cycles.
// Optional macro AES_KEY_FINAL_EN adds a dedicated step that drives k10 on o_final_key.
module aes_key_sched_seq
    import aes_pkg::*;
#(
    parameter int CC = 2
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic [127:0]            i_key_in,
    output logic [128*(NR/CC)-1:0]  o_round_keys,
    output logic                    o_valid,
    output logic                    o_last,
    output logic                    o_busy,
    output logic [127:0]            o_final_key
);

    localparam int KPC = NR / CC;
    localparam int CW  = $clog2(CC) + 1;

    aes_ks_state_t      r_state;
    aes_ks_state_t      w_state_next;
    aes_block_t         r_cur_key;
    logic [7:0]         r_rcon;
    logic [CW-1:0]      r_cnt;

    aes_block_t         w_k  [0:KPC];
    logic [7:0]         w_rc [0:KPC];
    logic [128*KPC-1:0] w_bundle;
    logic               w_is_last;
    aes_block_t         w_k10;

    assign w_k[0]    = r_cur_key;
    assign w_rc[0]   = r_rcon;
    assign w_is_last = (r_cnt == CW'(CC - 1));

    generate
        for (genvar gi = 0; gi < KPC; gi++) begin : g_chain
            aes_key_step u_step (
                .i_key  (w_k[gi]),
                .i_rcon (w_rc[gi]),
                .o_key  (w_k[gi+1]),
                .o_rcon (w_rc[gi+1])
            );
            assign w_bundle[128*gi +: 128] = w_k[gi];
        end
    endgenerate

`ifdef AES_KEY_FINAL_EN
    // Separate copy of the last chain step so the k10 output is decoupled from the feedback path.
    logic [7:0] w_rc_final;
    aes_key_step u_final (
        .i_key  (w_k[KPC-1]),
        .i_rcon (w_rc[KPC-1]),
        .o_key  (w_k10),
        .o_rcon (w_rc_final)
    );
`else
    assign w_k10 = '0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (i_start)   w_state_next = ST_RUN;
            ST_RUN:  if (w_is_last) w_state_next = ST_IDLE;
            default:                w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cur_key <= '0;
            r_rcon    <= 8'h01;
            r_cnt     <= '0;
        end else if (r_state == ST_IDLE) begin
            if (i_start) begin
                r_cur_key <= i_key_in;
                r_rcon    <= 8'h01;
                r_cnt     <= '0;
            end
        end else begin
            r_cur_key <= w_k[KPC];
            r_rcon    <= w_rc[KPC];
            if (!w_is_last) r_cnt <= r_cnt + CW'(1);
        end
    end

    always_comb begin
        o_round_keys = '0;
        o_valid      = 1'b0;
        o_last       = 1'b0;
        o_busy       = 1'b0;
        o_final_key  = '0;
        if (r_state == ST_RUN) begin
            o_round_keys = w_bundle;
            o_valid      = 1'b1;
            o_busy       = 1'b1;
            o_last       = w_is_last;
            if (w_is_last) o_final_key = w_k10;
        end
    end

endmodule

// File: tb/tb_aes_key_sched_seq.sv
// Randomized bench for aes_key_sched_seq at CC=2 and CC=10 against a FIPS-197 word-array model.
module tb_aes_key_sched_seq;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    logic         clk = 1'b0;
    logic         rst;
    logic         start2, start10;
    logic [127:0] key2, key10;
    logic [639:0] rk2;
    logic [127:0] rk10;
    logic         v2, l2, b2, v10, l10, b10;
    logic [127:0] fk2, fk10;

    always #5 clk = ~clk;

    aes_key_sched_seq #(.CC(2)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_start(start2), .i_key_in(key2),
        .o_round_keys(rk2), .o_valid(v2), .o_last(l2), .o_busy(b2), .o_final_key(fk2)
    );

    aes_key_sched_seq #(.CC(10)) dut10 (
        .i_clk(clk), .i_rst(rst), .i_start(start10), .i_key_in(key10),
        .o_round_keys(rk10), .o_valid(v10), .o_last(l10), .o_busy(b10), .o_final_key(fk10)
    );

    int           n_checks = 0;
    int           n_errors = 0;
    logic [7:0]   sbox_ref [0:255];
    logic [127:0] ref_rk   [0:10];
    logic [639:0] cap_rk   [0:9];
    logic [127:0] cap_fk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // S-box via the generator-3 walk over GF(2^8), independent of the RTL's inverse computation.
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sbox_ref[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox_ref[0] = 8'h63;
    endtask

    task automatic expand(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        int          rc;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 1;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_ref[t[31:24]], sbox_ref[t[23:16]], sbox_ref[t[15:8]], sbox_ref[t[7:0]]}
                    ^ {rc[7:0], 24'h000000};
                rc = rc * 2;
                if (rc > 255) rc = rc ^ 'h11b;
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) ref_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Starts at a negedge while the selected DUT is idle; returns at the negedge of the following IDLE cycle.
    task automatic run_sched(input int sel, input logic [127:0] key, input bit pulse, input bit scramble);
        int           cc, kpc, err0;
        logic         v, l, b;
        logic [639:0] rk;
        logic [127:0] fk, fk_exp;
        cc   = sel ? 10 : 2;
        kpc  = 10 / cc;
        err0 = n_errors;
        expand(key);
        if (sel != 0) begin start10 = 1'b1; key10 = key; end
        else          begin start2  = 1'b1; key2  = key; end
        @(posedge clk); #1;
        start2  = 1'b0;
        start10 = 1'b0;
        if (scramble) begin key2 = '1; key10 = '1; end
        for (int c = 0; c < cc; c++) begin
            @(negedge clk);
            rk = sel ? {512'b0, rk10} : rk2;
            v  = sel ? v10 : v2;
            l  = sel ? l10 : l2;
            b  = sel ? b10 : b2;
            fk = sel ? fk10 : fk2;
            cap_rk[c] = rk;
            check_eq($sformatf("valid_c%0d", c), 128'(v), 128'(1));
            check_eq($sformatf("busy_c%0d", c), 128'(b), 128'(1));
            check_eq($sformatf("last_c%0d", c), 128'(l), 128'(c == cc - 1));
            for (int i = 0; i < kpc; i++)
                check_eq($sformatf("slice%0d_c%0d", i, c), rk[128*i +: 128], ref_rk[c*kpc+i]);
            fk_exp = '0;
`ifdef AES_KEY_FINAL_EN
            if (c == cc - 1) fk_exp = ref_rk[10];
`endif
            if (c == cc - 1) cap_fk = fk;
            check_eq($sformatf("final_key_c%0d", c), fk, fk_exp);
            if (pulse) begin
                if (sel != 0) start10 = 1'b1;
                else          start2  = 1'b1;
            end
        end
        @(negedge clk);
        start2  = 1'b0;
        start10 = 1'b0;
        rk = sel ? {512'b0, rk10} : rk2;
        check_eq("idle_after_run",
                 128'({sel ? v10 : v2, sel ? b10 : b2, sel ? l10 : l2, |rk, |(sel ? fk10 : fk2)}),
                 128'(0));
        $display("run cc=%0d key=%h pulse=%0d scramble=%0d errors=%0d",
                 cc, key, pulse, scramble, n_errors - err0);
    endtask

    task automatic check_all_idle(input string tag);
        check_eq(tag, 128'({v2, b2, l2, |rk2, |fk2, v10, b10, l10, |rk10, |fk10}), 128'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        build_sbox();
        rst = 1'b1; start2 = 1'b0; start10 = 1'b0; key2 = '0; key10 = '0;
        @(negedge clk); @(negedge clk);
        check_all_idle("reset_state");
        $display("reset state checked");
        rst = 1'b0;

        repeat (20) begin
            @(negedge clk);
            check_all_idle("idle_no_start");
        end
        $display("idle window checked");

        // Nominal CC=2 with FIPS vectors
        run_sched(0, FIPS_KEY, 1'b0, 1'b0);
        check_eq("fips_k0", cap_rk[0][127:0], FIPS_KEY);
        check_eq("fips_k1", cap_rk[0][255:128], 128'ha0fafe1788542cb123a339392a6c7605);
        check_eq("fips_k5", cap_rk[1][127:0], 128'hd4d1c6f87c839d87caf2b8bc11f915bc);
`ifdef AES_KEY_FINAL_EN
        check_eq("fips_k10", cap_fk, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
`else
        check_eq("final_key_tied", cap_fk, 128'h0);
`endif

        // Rcon wrap at CC=10: bundles 9 and 10 use rcon 1B and 36
        run_sched(1, FIPS_KEY, 1'b0, 1'b0);
        check_eq("fips_k8", cap_rk[8][127:0], 128'head27321b58dbad2312bf5607f8d292f);
        check_eq("fips_k9", cap_rk[9][127:0], 128'hac7766f319fadc2128d12941575c006e);
`ifdef AES_KEY_FINAL_EN
        check_eq("fips_k10_cc10", cap_fk, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
`endif

        // Start held through RUN is ignored; start in the IDLE cycle begins the next schedule
        run_sched(0, FIPS_KEY, 1'b1, 1'b0);
        run_sched(0, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
        run_sched(1, FIPS_KEY, 1'b1, 1'b0);
        run_sched(1, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);

        // key_in scrambled after the accepting edge
        run_sched(0, FIPS_KEY, 1'b0, 1'b1);
        run_sched(1, FIPS_KEY, 1'b0, 1'b1);

        for (int n = 0; n < 8; n++)
            run_sched(n % 2, {$urandom, $urandom, $urandom, $urandom},
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        // Reset asserted in the second RUN cycle
        start2 = 1'b1; key2 = FIPS_KEY;
        @(posedge clk); #1; start2 = 1'b0;
        @(negedge clk);
        check_eq("pre_rst_valid", 128'(v2), 128'(1));
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check_eq("rst_mid_run", 128'({v2, b2, l2, |rk2}), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check_all_idle("after_rst_release");
        end
        $display("mid-run reset checked");

        run_sched(0, FIPS_KEY, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
